// File: rtl/seg_scan_capture.sv
// Receive side of a 4-digit multiplexed seven-segment scan. Synchronises the
// active-low anode/segment pins, qualifies each digit dwell, decodes it back to
// a nibble and commits the 16-bit value after FRAMES_MATCH identical frames.
// Optional macro SCAN_TIMEOUT_EN adds a watchdog that drives the stale output.
module seg_scan_capture #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned FRAMES_MATCH   = 2
`ifdef SCAN_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic [3:0]  anode_in,
    input  logic [6:0]  seg_in,
    output logic [15:0] value_out,
    output logic        valid,
    output logic        frame_err,
    output logic        stale
);

    typedef enum logic [1:0] {StIdle, StCollect, StCommit} state_e;

    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] MatchMax   = 4'(FRAMES_MATCH);

    logic [3:0]  r_anode_m, r_anode_s;
    logic [6:0]  r_seg_m, r_seg_s;
    logic [10:0] r_pat_prev;
    logic [7:0]  r_dwell;
    logic        r_done;
    logic [10:0] w_pat;
    logic        w_changed, w_qual;
    logic        w_multi;
    logic [1:0]  w_digit_idx;
    logic        w_seg_ok;
    logic [3:0]  w_nib;
    logic        w_bad;

    state_e      r_state, w_state_nxt;
    logic [1:0]  r_idx, w_idx_nxt;
    logic [15:0] r_frame, w_frame_nxt;
    logic [15:0] r_prev_frame, w_prev_nxt;
    logic [3:0]  r_match, w_match_nxt;
    logic [15:0] r_value, w_value_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_err, w_err_nxt;

    // Two-flop synchroniser; reset to the blank (all segments/anodes off) state.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            r_anode_m <= '1;
            r_anode_s <= '1;
            r_seg_m   <= '1;
            r_seg_s   <= '1;
        end else begin
            r_anode_m <= anode_in;
            r_anode_s <= r_anode_m;
            r_seg_m   <= seg_in;
            r_seg_s   <= r_seg_m;
        end
    end

    assign w_pat     = {r_anode_s, r_seg_s};
    assign w_changed = (w_pat != r_pat_prev);
    // Blank anodes never qualify; r_done stops a second qualification of one dwell.
    assign w_qual    = !w_changed && !r_done && (r_dwell == SettleLast) &&
                       (r_anode_s != 4'b1111);

    // Dwell counter: restart on any pattern change, otherwise count up and saturate.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            r_pat_prev <= '1;
            r_dwell    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_pat_prev <= w_pat;
            if (w_changed) begin
                r_dwell <= '0;
                r_done  <= 1'b0;
            end else begin
                if (r_dwell != 8'hFF) r_dwell <= r_dwell + 8'd1;
                if (w_qual) r_done <= 1'b1;
            end
        end
    end

    // Anode class: one-hot-low gives a digit index, anything but blank is an error.
    always_comb begin
        w_multi     = 1'b0;
        w_digit_idx = 2'd0;
        unique case (r_anode_s)
            4'b1110: w_digit_idx = 2'd0;
            4'b1101: w_digit_idx = 2'd1;
            4'b1011: w_digit_idx = 2'd2;
            4'b0111: w_digit_idx = 2'd3;
            4'b1111: w_multi     = 1'b0;
            default: w_multi     = 1'b1;
        endcase
    end

    // Segment pattern (g..a, active-low) back to a hex nibble.
    always_comb begin
        w_seg_ok = 1'b1;
        w_nib    = 4'h0;
        case (r_seg_s)
            7'b1000000: w_nib = 4'h0;
            7'b1111001: w_nib = 4'h1;
            7'b0100100: w_nib = 4'h2;
            7'b0110000: w_nib = 4'h3;
            7'b0011001: w_nib = 4'h4;
            7'b0010010: w_nib = 4'h5;
            7'b0000010: w_nib = 4'h6;
            7'b1111000: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0010000: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b0000011: w_nib = 4'hB;
            7'b1000110: w_nib = 4'hC;
            7'b0100001: w_nib = 4'hD;
            7'b0000110: w_nib = 4'hE;
            7'b0001110: w_nib = 4'hF;
            default:    w_seg_ok = 1'b0;
        endcase
    end

    assign w_bad = w_multi || !w_seg_ok;

`ifdef SCAN_TIMEOUT_EN
    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_wdog;
    logic        r_stale;
    logic        w_timeout;

    assign w_timeout = !w_qual && (r_wdog == TimeoutVal - 16'd1);

    // Watchdog: cycles since the last qualified digit; stale holds until the next one.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            r_wdog  <= '0;
            r_stale <= 1'b0;
        end else if (w_qual) begin
            r_wdog  <= '0;
            r_stale <= 1'b0;
        end else begin
            if (r_wdog != TimeoutVal) r_wdog <= r_wdog + 16'd1;
            if (w_timeout) r_stale <= 1'b1;
        end
    end

    assign stale = r_stale;
`else
    assign stale = 1'b0;
`endif

    // Frame assembly FSM: next state, frame contents, match tracking and output pulses.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_frame_nxt = r_frame;
        w_prev_nxt  = r_prev_frame;
        w_match_nxt = r_match;
        w_value_nxt = r_value;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_qual) begin
                    if (w_bad) begin
                        w_err_nxt   = 1'b1;
                        w_match_nxt = '0;
                    end else if (w_digit_idx == 2'd0) begin
                        w_frame_nxt[3:0] = w_nib;
                        w_idx_nxt        = 2'd1;
                        w_state_nxt      = StCollect;
                    end
                end
            end
            StCollect: begin
                if (w_qual) begin
                    if (w_bad) begin
                        w_err_nxt   = 1'b1;
                        w_match_nxt = '0;
                        w_state_nxt = StIdle;
                    end else if (w_digit_idx == r_idx) begin
                        w_frame_nxt[{r_idx, 2'b00} +: 4] = w_nib;
                        if (r_idx == 2'd3) w_state_nxt = StCommit;
                        else               w_idx_nxt   = r_idx + 2'd1;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_match_nxt = '0;
                        // An out-of-order digit0 is a valid start of the next frame.
                        if (w_digit_idx == 2'd0) begin
                            w_frame_nxt[3:0] = w_nib;
                            w_idx_nxt        = 2'd1;
                        end else begin
                            w_state_nxt = StIdle;
                        end
                    end
                end
            end
            StCommit: begin
                if (r_frame == r_prev_frame) begin
                    w_match_nxt = (r_match == MatchMax) ? r_match : r_match + 4'd1;
                end else begin
                    w_match_nxt = 4'd1;
                    w_prev_nxt  = r_frame;
                end
                if (w_match_nxt == MatchMax) begin
                    w_value_nxt = r_frame;
                    w_valid_nxt = 1'b1;
                end
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
`ifdef SCAN_TIMEOUT_EN
        if (w_timeout) w_state_nxt = StIdle;
`endif
    end

    // FSM and datapath registers.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_idx        <= 2'd0;
            r_frame      <= '0;
            r_prev_frame <= '0;
            r_match      <= '0;
            r_value      <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_frame      <= w_frame_nxt;
            r_prev_frame <= w_prev_nxt;
            r_match      <= w_match_nxt;
            r_value      <= w_value_nxt;
            r_valid      <= w_valid_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign value_out = r_value;
    assign valid     = r_valid;
    assign frame_err = r_err;

endmodule
